// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller.
// Contents:
//   vend_state_e  controller states (IDLE, CREDIT, DISPENSE, CHANGE)
//   COIN_*        2-bit coin event codes
//   coin_value()  credit value of a coin code (0 for none/invalid)
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_LO   = 2'b01;
    localparam logic [1:0] COIN_HI   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    function automatic int unsigned coin_value(input logic [1:0] code,
                                               input int unsigned lo_val,
                                               input int unsigned hi_val);
        case (code)
            COIN_LO:  return lo_val;
            COIN_HI:  return hi_val;
            COIN_NONE,
            COIN_BAD: return 0;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_txn_controller_if.sv
// Handshake bundle between the vending controller and its surroundings
// (coin acceptor / keypad, dispenser, change hopper).
// Signals:
//   coin[1:0], sel, cancel     coin and keypad events (one-cycle pulses)
//   disp_req / disp_ack        dispenser handshake
//   chg_req / chg_ack          change-hopper handshake, one unit per req&ack cycle
//   credit[CREDIT_W-1:0]       current credit
//   busy, vend_done, coin_reject, timeout   status outputs
// Modports: slave = controller side, master = environment side.
interface vend_txn_controller_if #(
    parameter int unsigned CREDIT_W = 6
);
    logic [1:0]          coin;
    logic                sel;
    logic                cancel;
    logic                disp_req;
    logic                disp_ack;
    logic                chg_req;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                vend_done;
    logic                coin_reject;
    logic                timeout;

    modport slave (
        input  coin, sel, cancel, disp_ack, chg_ack,
        output disp_req, chg_req, credit, busy, vend_done, coin_reject, timeout
    );

    modport master (
        output coin, sel, cancel, disp_ack, chg_ack,
        input  disp_req, chg_req, credit, busy, vend_done, coin_reject, timeout
    );
endinterface

// File: rtl/vend_idle_timer.sv
// Idle timer for the CREDIT state. Counts down from TIMEOUT_CYC-1 while run
// is high and clear is low; expire is high on the cycle the count is at zero,
// i.e. on the TIMEOUT_CYC-th consecutive quiet cycle.
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   run     controller is in CREDIT; count is reloaded when low
//   clear   activity this cycle; reloads the count
//   expire  terminal-count pulse (combinational from the count)
module vend_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= RELOAD;
        end else if (!run || clear) begin
            cnt_q <= RELOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = run && !clear && (cnt_q == '0);
endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: accumulates coin credit, runs the dispenser
// handshake on a covered vend request, then pays change one unit per hopper
// handshake. All outputs are registered.
// Optional feature: define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC
// quiet cycles in CREDIT (timeout output pulses); otherwise timeout is 0.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    vend_txn_controller_if.slave (coin/sel/cancel in, dispenser and
//          hopper handshakes, credit/busy/vend_done/coin_reject/timeout out)
//
// state    | meaning
// IDLE     | no credit, waiting for a coin
// CREDIT   | credit held, waiting for sel / cancel / more coins
// DISPENSE | disp_req high until disp_ack
// CHANGE   | paying out credit one CHANGE_UNIT per chg_req&chg_ack
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE       = 15,
    parameter int unsigned COIN_LO_VAL = 5,
    parameter int unsigned COIN_HI_VAL = 10,
    parameter int unsigned CHANGE_UNIT = 5,
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    vend_txn_controller_if.slave  bus
);
    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [SUM_W-1:0] PRICE_V    = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0] UNIT_V     = SUM_W'(CHANGE_UNIT);

    if ((PRICE % CHANGE_UNIT) != 0 || (COIN_LO_VAL % CHANGE_UNIT) != 0 ||
        (COIN_HI_VAL % CHANGE_UNIT) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("vend_txn_controller: values must be multiples of CHANGE_UNIT, TIMEOUT_CYC >= 2");
    end

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SUM_W-1:0]    coin_val, credit_ext, credit_sum, nxt;
    logic                coin_accept, tmr_expire;
    logic disp_req_q, chg_req_q, busy_q, vend_done_q, coin_reject_q, timeout_q;
    logic disp_req_d, chg_req_d, busy_d, vend_done_d, coin_reject_d, timeout_d;

    always_comb begin
        coin_val    = SUM_W'(coin_value(bus.coin, COIN_LO_VAL, COIN_HI_VAL));
        credit_ext  = {1'b0, credit_q};
        credit_sum  = credit_ext + coin_val;
        coin_accept = (state_q == IDLE || state_q == CREDIT) && (coin_val != '0)
                      && (credit_sum <= CREDIT_MAX);
    end

`ifdef VEND_TIMEOUT_EN
    logic activity;
    assign activity = (bus.coin != COIN_NONE) || bus.sel || bus.cancel;

    vend_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == CREDIT),
        .clear  (activity),
        .expire (tmr_expire)
    );
`else
    assign tmr_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            vend_done_q   <= 1'b0;
            coin_reject_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            chg_req_q     <= chg_req_d;
            busy_q        <= busy_d;
            vend_done_q   <= vend_done_d;
            coin_reject_q <= coin_reject_d;
            timeout_q     <= timeout_d;
        end
    end

    // Outside IDLE/CREDIT coin_accept is 0, so the default keeps credit as is.
    always_comb begin
        state_d = state_q;
        nxt     = coin_accept ? credit_sum : credit_ext;
        case (state_q)
            IDLE: begin
                if (coin_accept) state_d = CREDIT;
            end
            CREDIT: begin
                // sel is judged on registered credit; a same-cycle coin still lands.
                if (bus.cancel) begin
                    state_d = CHANGE;
                end else if (bus.sel && credit_ext >= PRICE_V) begin
                    state_d = DISPENSE;
                    nxt     = nxt - PRICE_V;
                end else if (tmr_expire) begin
                    state_d = CHANGE;
                end
            end
            DISPENSE: begin
                if (bus.disp_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit_ext < UNIT_V) begin
                    // Residue smaller than one payout cannot be returned; drop it.
                    nxt     = '0;
                    state_d = IDLE;
                end else if (chg_req_q && bus.chg_ack) begin
                    nxt = credit_ext - UNIT_V;
                    if (nxt == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        credit_d = nxt[CREDIT_W-1:0];
    end

    always_comb begin
        disp_req_d    = (state_d == DISPENSE);
        chg_req_d     = (state_d == CHANGE) && ({1'b0, credit_d} >= UNIT_V);
        busy_d        = (state_d == DISPENSE) || (state_d == CHANGE);
        vend_done_d   = (state_q == DISPENSE) && bus.disp_ack;
        coin_reject_d = (bus.coin != COIN_NONE) && !coin_accept;
        timeout_d     = (state_q == CREDIT) && (state_d == CHANGE) && !bus.cancel;
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.chg_req     = chg_req_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;
    assign bus.vend_done   = vend_done_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.timeout     = timeout_q;

`ifndef SYNTHESIS
    a_change_residue: assert property (@(posedge clk) disable iff (!reset)
        (state_q == CHANGE) |-> (credit_q == '0 || {1'b0, credit_q} >= UNIT_V));
`endif
endmodule

// File: tb/tb_vend_txn_controller.sv
module tb_vend_txn_controller;
    import vend_pkg::*;

    localparam int CREDIT_W = 6;
    localparam int EV_DISP = 0, EV_DONE = 1, EV_TMO = 2, EV_CHG = 3, EV_REJ = 4;

    typedef struct {
        int kind;
        int credit;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vend_txn_controller_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_txn_controller #(
        .PRICE(15), .COIN_LO_VAL(5), .COIN_HI_VAL(10), .CHANGE_UNIT(5),
        .CREDIT_W(CREDIT_W), .TIMEOUT_CYC(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int cr);
        ev_t e;
        e.kind   = kind;
        e.credit = cr;
        exp_q.push_back(e);
    endtask

    task automatic score(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d credit %0d, expected no event",
                     kind, int'(bus.credit));
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_credit", int'(bus.credit), e.credit);
        end
    endtask

    // Monitor: every output event is matched against the scoreboard queue.
    logic prev_disp = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (bus.disp_req && !prev_disp) score(EV_DISP);
            if (bus.vend_done)              score(EV_DONE);
            if (bus.timeout)                score(EV_TMO);
            if (bus.chg_req && bus.chg_ack) score(EV_CHG);
            if (bus.coin_reject)            score(EV_REJ);
        end
        prev_disp = bus.disp_req;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin_in(input logic [1:0] c);
        bus.coin = c;
        cyc();
        bus.coin = COIN_NONE;
    endtask

    task automatic pulse(input logic s, input logic c, input logic [1:0] cn);
        bus.sel    = s;
        bus.cancel = c;
        bus.coin   = cn;
        cyc();
        bus.sel    = 1'b0;
        bus.cancel = 1'b0;
        bus.coin   = COIN_NONE;
    endtask

    task automatic dispense(input int delay);
        int n = 0;
        while (!bus.disp_req && n < 50) begin
            cyc();
            n++;
        end
        if (!bus.disp_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL disp_wait: disp_req still %0d after 50 cycles, expected 1", bus.disp_req);
        end else begin
            cyc(delay);
            chk("disp_req_held", int'(bus.disp_req), 1);
            bus.disp_ack = 1'b1;
            cyc();
            bus.disp_ack = 1'b0;
        end
    endtask

    task automatic change(input int units);
        for (int i = 0; i < units; i++) begin
            int n = 0;
            while (!bus.chg_req && n < 50) begin
                cyc();
                n++;
            end
            if (!bus.chg_req) begin
                n_tests++;
                n_fail++;
                $display("FAIL chg_wait: chg_req still 0 after 50 cycles at unit %0d, expected 1", i);
                break;
            end
            bus.chg_ack = 1'b1;
            cyc();
            bus.chg_ack = 1'b0;
            cyc();
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_credit"}, int'(bus.credit), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_reqs"}, int'({bus.disp_req, bus.chg_req}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.coin     = COIN_NONE;
        bus.sel      = 1'b0;
        bus.cancel   = 1'b0;
        bus.disp_ack = 1'b0;
        bus.chg_ack  = 1'b0;
        cyc(3);
        chk("reset_flags", int'({bus.disp_req, bus.chg_req, bus.busy, bus.vend_done,
                                 bus.coin_reject, bus.timeout}), 0);
        chk("reset_credit", int'(bus.credit), 0);
        reset = 1'b1;
        cyc(2);

        // Exact price with three LO coins, no change.
        coin_in(COIN_LO);
        coin_in(COIN_LO);
        coin_in(COIN_LO);
        chk("t1_credit15", int'(bus.credit), 15);
        expect_ev(EV_DISP, 0);
        pulse(1'b1, 1'b0, COIN_NONE);
        chk("t1_busy_disp", int'(bus.busy), 1);
        expect_ev(EV_DONE, 0);
        dispense(2);
        cyc(2);
        chk_idle("t1_end");

        // Overpay 20, vend, one unit of change.
        coin_in(COIN_HI);
        coin_in(COIN_HI);
        expect_ev(EV_DISP, 5);
        pulse(1'b1, 1'b0, COIN_NONE);
        expect_ev(EV_DONE, 5);
        expect_ev(EV_CHG, 5);
        dispense(2);
        change(1);
        cyc(2);
        chk_idle("t2_end");

        // Insufficient sel ignored, then cancel refunds 10.
        coin_in(COIN_HI);
        pulse(1'b1, 1'b0, COIN_NONE);
        cyc();
        chk("t3_sel_ignored_credit", int'(bus.credit), 10);
        chk("t3_sel_ignored_busy", int'(bus.busy), 0);
        expect_ev(EV_CHG, 10);
        expect_ev(EV_CHG, 5);
        pulse(1'b0, 1'b1, COIN_NONE);
        change(2);
        cyc(2);
        chk_idle("t3_end");

        // Coin during DISPENSE and invalid coin codes are rejected.
        coin_in(COIN_HI);
        coin_in(COIN_LO);
        expect_ev(EV_DISP, 0);
        pulse(1'b1, 1'b0, COIN_NONE);
        expect_ev(EV_REJ, 0);
        coin_in(COIN_LO);
        chk("t4_rej_disp_credit", int'(bus.credit), 0);
        expect_ev(EV_DONE, 0);
        dispense(1);
        cyc(2);
        expect_ev(EV_REJ, 0);
        coin_in(COIN_BAD);
        chk_idle("t4_bad_idle");
        coin_in(COIN_LO);
        expect_ev(EV_REJ, 5);
        coin_in(COIN_BAD);
        chk("t4_bad_credit", int'(bus.credit), 5);
        // Cancel with a same-cycle HI coin: coin is added, then refunded.
        expect_ev(EV_CHG, 15);
        expect_ev(EV_CHG, 10);
        expect_ev(EV_CHG, 5);
        pulse(1'b0, 1'b1, COIN_HI);
        change(3);
        cyc(2);
        chk_idle("t4_end");

        // Saturation at the credit limit.
        repeat (6) coin_in(COIN_HI);
        chk("t5_credit60", int'(bus.credit), 60);
        expect_ev(EV_REJ, 60);
        coin_in(COIN_HI);
        expect_ev(EV_REJ, 60);
        coin_in(COIN_LO);
        chk("t5_sat_credit", int'(bus.credit), 60);
        for (int k = 12; k >= 1; k--) expect_ev(EV_CHG, 5 * k);
        pulse(1'b0, 1'b1, COIN_NONE);
        change(12);
        cyc(2);
        chk_idle("t5_refund_end");

        // cancel beats sel in the same cycle.
        coin_in(COIN_HI);
        coin_in(COIN_LO);
        expect_ev(EV_CHG, 15);
        expect_ev(EV_CHG, 10);
        expect_ev(EV_CHG, 5);
        pulse(1'b1, 1'b1, COIN_NONE);
        change(3);
        cyc(2);
        chk_idle("t5_cancel_sel_end");

        // sel uses registered credit; same-cycle coin is still added.
        coin_in(COIN_HI);
        pulse(1'b1, 1'b0, COIN_LO);
        cyc();
        chk("t6_sel_pre_coin_credit", int'(bus.credit), 15);
        chk("t6_sel_pre_coin_busy", int'(bus.busy), 0);
        expect_ev(EV_DISP, 10);
        pulse(1'b1, 1'b0, COIN_HI);
        expect_ev(EV_DONE, 10);
        expect_ev(EV_CHG, 10);
        expect_ev(EV_CHG, 5);
        dispense(1);
        change(2);
        cyc(2);
        chk_idle("t6_end");

        // Asynchronous reset in the middle of a dispense handshake.
        coin_in(COIN_HI);
        coin_in(COIN_HI);
        expect_ev(EV_DISP, 5);
        pulse(1'b1, 1'b0, COIN_NONE);
        cyc();
        chk("t7_pre_reset_disp", int'(bus.disp_req), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_async_flags", int'({bus.disp_req, bus.chg_req, bus.busy, bus.vend_done,
                                    bus.coin_reject, bus.timeout}), 0);
        chk("t7_async_credit", int'(bus.credit), 0);
        cyc(2);
        reset = 1'b1;
        bus.disp_ack = 1'b1;
        cyc();
        bus.disp_ack = 1'b0;
        cyc(2);
        chk_idle("t7_after_release");
        coin_in(COIN_LO);
        chk("t7_accepts_coin", int'(bus.credit), 5);
        expect_ev(EV_CHG, 5);
        pulse(1'b0, 1'b1, COIN_NONE);
        change(1);
        cyc(2);
        chk_idle("t7_end");

`ifdef VEND_TIMEOUT_EN
        // 16 quiet cycles after a coin trigger a full refund.
        expect_ev(EV_TMO, 5);
        expect_ev(EV_CHG, 5);
        coin_in(COIN_LO);
        n = 0;
        while (!bus.chg_req && n < 40) begin
            cyc();
            n++;
        end
        chk("t8_timeout_latency", n, 16);
        change(1);
        cyc(2);
        chk_idle("t8_end");
        // An ignored sel still restarts the idle count.
        coin_in(COIN_LO);
        cyc(10);
        expect_ev(EV_TMO, 5);
        expect_ev(EV_CHG, 5);
        pulse(1'b1, 1'b0, COIN_NONE);
        n = 0;
        while (!bus.chg_req && n < 40) begin
            cyc();
            n++;
        end
        chk("t8_timeout_restart", n, 16);
        change(1);
        cyc(2);
        chk_idle("t8_restart_end");
`else
        // Without the timeout feature credit is held indefinitely.
        coin_in(COIN_LO);
        cyc(40);
        chk("t8_hold_credit", int'(bus.credit), 5);
        chk("t8_hold_chg_req", int'(bus.chg_req), 0);
        chk("t8_hold_timeout", int'(bus.timeout), 0);
        expect_ev(EV_CHG, 5);
        pulse(1'b0, 1'b1, COIN_NONE);
        change(1);
        cyc(2);
        chk_idle("t8_end");
        n = 0;
`endif

        cyc(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
